// File: rtl/fsm_pattern_pkg.sv
// Shared definitions for the "11"-marker serial link (transmitter and detector sides).
package fsm_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC1 = 3'd1,
    ST_SYNC2 = 3'd2,
    ST_DATA  = 3'd3,
    ST_STUFF = 3'd4,
    ST_END   = 3'd5
  } state_t;

  localparam logic [1:0] SYNC_MARKER = 2'b11;

endpackage

// File: rtl/fsm_piso_shift.sv
// Parallel-in serial-out shift register, MSB first, zero fill on shift.
module fsm_piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   shreg <= '0;
    else if (load)  shreg <= din;
    else if (shift) shreg <= {shreg[DATA_W-2:0], 1'b0};
  end

  assign msb = shreg[DATA_W-1];

endmodule

// File: rtl/fsm_pattern_tx.sv
// Serial frame transmitter: "11" marker, bit-stuffed payload MSB-first, 0 trailer.
module fsm_pattern_tx
  import fsm_pattern_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              out_bit,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             load, shift, msb;

  fsm_piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (shift),
    .din     (data_in),
    .msb     (msb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Counter is only reloaded on accept, so it parks at 0 between frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   bit_cnt <= '0;
    else if (load)  bit_cnt <= CNT_W'(DATA_W);
    else if (shift) bit_cnt <= bit_cnt - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      ST_IDLE: if (data_valid) begin
        load      = 1'b1;
        state_nxt = ST_SYNC1;
      end
      ST_SYNC1: state_nxt = ST_SYNC2;
      ST_SYNC2: state_nxt = ST_DATA;
      ST_DATA: begin
        shift = 1'b1;
        if (msb)                         state_nxt = ST_STUFF;
        else if (bit_cnt == CNT_W'(1))   state_nxt = ST_END;
      end
      ST_STUFF: state_nxt = (bit_cnt == '0) ? ST_END : ST_DATA;
      ST_END:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode; illegal encodings drive the idle level.
  always_comb begin
    out_bit    = 1'b0;
    frame_done = 1'b0;
    data_ready = (state == ST_IDLE);
    tx_busy    = (state != ST_IDLE);
    case (state)
      ST_SYNC1: out_bit    = SYNC_MARKER[1];
      ST_SYNC2: out_bit    = SYNC_MARKER[0];
      ST_DATA:  out_bit    = msb;
      ST_END:   frame_done = 1'b1;
      default:  out_bit    = 1'b0;
    endcase
  end

endmodule
